// File: rtl/mult_seq_if.sv
// mult_seq_if: operand/result bundle of the iterative multiplier.
//   master : drives start, sgn, a, b; observes busy, done, hi, lo (controller side)
//   slave  : the multiplier itself
//   start  : one-cycle request, sampled only while the multiplier is idle
//   sgn    : 1 = signed (MULT), 0 = unsigned (MULTU)
//   a, b   : multiplicand (rs) and multiplier (rt)
//   busy   : high while iterating
//   done   : one-cycle pulse, hi/lo just updated
//   hi, lo : upper/lower halves of the registered 2*WIDTH-bit product
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sgn, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: radix-2 shift-add multiplier, one operand bit per cycle.
//   clk   : system clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : mult_seq_if slave port (start/sgn/a/b in, busy/done/hi/lo out)
// Signed operands are reduced to magnitudes on acceptance; the sign of the
// product is re-applied only when the final result is written to hi/lo, so
// the result registers never expose partial sums.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mult_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand magnitude
  logic [WIDTH-1:0]   mplier_q, mplier_d;  // multiplier; low product bits shift in from the top
  logic [WIDTH-1:0]   acc_q, acc_d;        // upper half of the running product
  logic               neg_q, neg_d;        // final product must be negated
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum;                 // carry-preserving partial sum
  logic [2*WIDTH-1:0] mag;                 // product magnitude after the last step

  // |x| when signed mode is requested; the most negative value maps onto
  // itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x,
                                               input logic             en);
    if (en && x[WIDTH-1]) begin
      return {WIDTH{1'b0}} - x;
    end else begin
      return x;
    end
  endfunction

  // Next-state, datapath step and result write.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = {(WIDTH+1){1'b0}};
    mag      = {(2*WIDTH){1'b0}};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = abs_val(bus.a, bus.sgn);
          mplier_d = abs_val(bus.b, bus.sgn);
          neg_d    = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end

      RUN: begin
        sum      = {1'b0, acc_q} +
                   (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        // Shift {carry, acc, multiplier} right by one.
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        mag      = {acc_d, mplier_d};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          if (neg_q) begin
            {hi_d, lo_d} = {(2*WIDTH){1'b0}} - mag;
          end else begin
            {hi_d, lo_d} = mag;
          end
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Outputs come straight from registers or state decode.
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed plus randomized check of mult_seq against a 64-bit
// arithmetic reference product.
module tb_mult_seq;

  logic clk = 1'b0;
  logic reset;

  mult_seq_if #(.WIDTH(32)) bus ();

  mult_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] prev   = 64'd0;   // last completed product, expected on hi/lo

  function automatic logic [63:0] ref_prod(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic        s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end else begin
      return {32'd0, x} * {32'd0, y};
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One multiply from idle; operands are scrambled every cycle while running.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic s, input bit perturb, input string tag);
    logic [63:0] exp;
    int          busy_cnt;
    int          lat;
    bit          held;
    bit          overlap;
    bit          got;
    exp      = ref_prod(x, y, s);
    busy_cnt = 0;
    lat      = 0;
    held     = 1'b1;
    overlap  = 1'b0;
    got      = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.sgn = s;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        got = 1'b1;
        lat = k;
      end else if ({bus.hi, bus.lo} !== prev) begin
        held = 1'b0;
      end
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.sgn   = 1'($urandom_range(0, 1));
      if (perturb && k == 10) begin
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.sgn   = ~s;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " busy&done"}, 64'(overlap), 64'd0);
    check({tag, " hi/lo held"}, 64'(held), 64'd1);
    check({tag, " product"}, {bus.hi, bus.lo}, exp);
    @(negedge clk);
    check({tag, " done width"}, 64'(bus.done), 64'd0);
    check({tag, " idle after"}, 64'(bus.busy), 64'd0);
    prev = exp;
  endtask

  initial begin
    bit          seen;
    bit          found;
    int          c;
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [63:0] exp;

    reset = 1'b1; bus.start = 1'b0; bus.sgn = 1'b0;
    bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    // Directed products.
    run_op(32'd3, 32'd5, 1'b0, 1'b0, "u 3*5");
    check("u 3*5 const", prev, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "u max");
    check("u max const", prev, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFF9, 32'd3, 1'b1, 1'b0, "s -7*3");
    check("s -7*3 const", prev, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "s min*min");
    check("s min*min const", prev, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "s -1*-1");
    check("s -1*-1 const", prev, 64'h0000_0000_0000_0001);
    run_op(32'd6, 32'd7, 1'b0, 1'b1, "ignored start");
    check("ignored start const", prev, 64'd42);

    // Reset in the middle of an operation, together with a start request.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h1234; bus.b = 32'h5678; bus.sgn = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    check("mid reset busy", 64'(bus.busy), 64'd0);
    check("mid reset done", 64'(bus.done), 64'd0);
    check("mid reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0; bus.start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("no done after abort", 64'(seen), 64'd0);
    prev = 64'd0;
    run_op(32'd2, 32'd2, 1'b0, 1'b0, "after reset 2*2");
    check("after reset const", prev, 64'd4);

    // Back-to-back random run with start held high.
    @(negedge clk);
    x = pick_operand(); y = pick_operand(); s = 1'($urandom_range(0, 1));
    exp = ref_prod(x, y, s);
    bus.start = 1'b1; bus.a = x; bus.b = y; bus.sgn = s;
    for (int n = 0; n < 1000; n++) begin
      found = 1'b0;
      c     = 0;
      while (!found && c < 40) begin
        @(negedge clk);
        c++;
        if (bus.done) found = 1'b1;
      end
      check("b2b done seen", 64'(found), 64'd1);
      check("b2b interval", 64'(c), (n == 0) ? 64'd33 : 64'd34);
      check("b2b product", {bus.hi, bus.lo}, exp);
      x = pick_operand(); y = pick_operand(); s = 1'($urandom_range(0, 1));
      exp = ref_prod(x, y, s);
      bus.a = x; bus.b = y; bus.sgn = s;
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
